// File: rtl/ef_pwm32_cap_pkg.sv
// Shared types and defaults for the PWM input capture unit.
// Holds the FSM state encoding and the default widths.
package ef_pwm32_cap_pkg;

    localparam int W_DEF          = 32;
    localparam int FILTER_LEN_DEF = 4;
    localparam int PSC_W          = 8;

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        HIGH,
        LOW
    } state_t;

endpackage

// File: rtl/ef_pwm32_cap_sync.sv
// Pin synchronizer, optional glitch filter, inversion and edge detect.
// The glitch filter is built only when EF_PWM32_CAP_FILTER_EN is defined.
import ef_pwm32_cap_pkg::*;

module ef_pwm32_cap_sync #(
    parameter int FILTER_LEN = FILTER_LEN_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_in,
    input  logic inv,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic flt;
    logic cur;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= pwm_in;
            s2 <= s1;
        end
    end

`ifdef EF_PWM32_CAP_FILTER_EN
    localparam int CW = $clog2(FILTER_LEN + 1);

    logic [CW-1:0] fcnt;
    logic          filt;

    // New value must persist FILTER_LEN cycles before it is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt <= '0;
            filt <= 1'b0;
        end else if (s2 == filt) begin
            fcnt <= '0;
        end else if (fcnt == CW'(FILTER_LEN - 1)) begin
            fcnt <= '0;
            filt <= s2;
        end else begin
            fcnt <= fcnt + CW'(1);
        end
    end

    assign flt = filt;
`else
    assign flt = s2;
`endif

    assign cur = flt ^ inv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev <= 1'b0;
        end else begin
            prev <= cur;
        end
    end

    assign level = prev;
    assign rise  = cur & ~prev;
    assign fall  = ~cur & prev;

endmodule

// File: rtl/ef_pwm32_capture.sv
// PWM input capture: period and high time in prescaled ticks, with timeout.
// Optional glitch filter enabled by defining EF_PWM32_CAP_FILTER_EN.
import ef_pwm32_cap_pkg::*;

module ef_pwm32_capture #(
    parameter int W          = W_DEF,
    parameter int FILTER_LEN = FILTER_LEN_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             pwm_in,
    input  logic             inv,
    input  logic [PSC_W-1:0] prescale,
    input  logic [W-1:0]     timeout,
    output logic [W-1:0]     period,
    output logic [W-1:0]     high_time,
    output logic             valid,
    output logic             timeout_evt,
    output logic             level,
    output logic             busy
);

    logic rise;
    logic fall;

    ef_pwm32_cap_sync #(
        .FILTER_LEN(FILTER_LEN)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .pwm_in(pwm_in),
        .inv   (inv),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    state_t           state_q;
    state_t           state_n;
    logic [PSC_W-1:0] psc_q;
    logic [W-1:0]     cnt_q;
    logic [W-1:0]     cnt_nxt;
    logic [W-1:0]     high_q;
    logic [W-1:0]     period_q;
    logic [W-1:0]     high_time_q;
    logic             valid_q;
    logic             evt_q;
    logic             tick;
    logic             to_hit;
    logic             clear;
    logic             restart;
    logic             lat_high;
    logic             lat_per;
    logic             valid_n;
    logic             evt_n;

    assign tick = (psc_q == prescale);

    // Include this cycle's tick so N cycles yield floor(N/(P+1)) ticks
    assign cnt_nxt = (tick && !(&cnt_q)) ? cnt_q + W'(1) : cnt_q;

    assign to_hit = (timeout != '0) && (cnt_nxt >= timeout);

    always_comb begin
        state_n  = state_q;
        clear    = 1'b0;
        restart  = 1'b0;
        lat_high = 1'b0;
        lat_per  = 1'b0;
        valid_n  = 1'b0;
        evt_n    = 1'b0;
        if (!en) begin
            state_n = IDLE;
            clear   = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_n = ARM;
                    clear   = 1'b1;
                end
                ARM: begin
                    if (rise) begin
                        state_n = HIGH;
                        restart = 1'b1;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        state_n  = LOW;
                        lat_high = 1'b1;
                    end else if (to_hit) begin
                        state_n = ARM;
                        evt_n   = 1'b1;
                    end
                end
                LOW: begin
                    if (rise) begin
                        state_n = HIGH;
                        restart = 1'b1;
                        lat_per = 1'b1;
                        valid_n = 1'b1;
                    end else if (to_hit) begin
                        state_n = ARM;
                        evt_n   = 1'b1;
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            psc_q <= '0;
            cnt_q <= '0;
        end else if (clear || restart) begin
            psc_q <= '0;
            cnt_q <= '0;
        end else begin
            psc_q <= tick ? '0 : psc_q + PSC_W'(1);
            cnt_q <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            high_q      <= '0;
            period_q    <= '0;
            high_time_q <= '0;
            valid_q     <= 1'b0;
            evt_q       <= 1'b0;
        end else begin
            valid_q <= valid_n;
            evt_q   <= evt_n;
            if (lat_high) begin
                high_q <= cnt_nxt;
            end
            if (lat_per) begin
                period_q    <= cnt_nxt;
                high_time_q <= high_q;
            end
        end
    end

    assign period      = period_q;
    assign high_time   = high_time_q;
    assign valid       = valid_q;
    assign timeout_evt = evt_q;
    assign busy        = (state_q == HIGH) || (state_q == LOW);

endmodule
